hazard_fwd_ctrl: RTL and testbench

// - Hazard/forwarding controller for the 5-stage pipeline; drives the Forward_Sel inputs of every mf operand mux and the D-stage stall.
// - Keeps its own E/M/W shadow pipeline of {dest reg, Tnew, result kind}, fed from decoded D-stage info.
// - Compares that pipeline against D-, E- and M-stage source registers using the Tuse/Tnew rule.

---
 rtl/hazard_fwd_ctrl_pkg.sv | 21 ++
 rtl/hazard_fwd_ctrl_if.sv | 33 +++
 rtl/fwd_pick.sv | 46 ++++
 rtl/hazard_fwd_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared result-kind and forward-select encodings for the hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

  localparam int unsigned RW_DEF = 5;
  localparam int unsigned TW_DEF = 2;

  typedef enum logic [1:0] {
    RK_ALU  = 2'd0,
    RK_LINK = 2'd1,
    RK_MEM  = 2'd2
  } rk_e;

  typedef enum logic [2:0] {
    MF_RD   = 3'd0,
    MF_PC4E = 3'd1,
    MF_AO   = 3'd2,
    MF_PC4M = 3'd3,
    MF_WD   = 3'd4
  } mf_e;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// D-stage decode info into the controller; stall and mux selects back out.
interface hazard_fwd_ctrl_if
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned TW = TW_DEF
);

  logic [RW-1:0] rs_D;
  logic [RW-1:0] rt_D;
  logic [TW-1:0] tuse_rs_D;
  logic [TW-1:0] tuse_rt_D;
  logic [RW-1:0] a3_D;
  logic [TW-1:0] tnew_D;
  rk_e           kind_D;
  logic          stall;
  mf_e           fsel_rs_D;
  mf_e           fsel_rt_D;
  mf_e           fsel_rs_E;
  mf_e           fsel_rt_E;
  mf_e           fsel_rt_M;

  modport master (
    output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, kind_D,
    input  stall, fsel_rs_D, fsel_rt_D, fsel_rs_E, fsel_rt_E, fsel_rt_M
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, kind_D,
    output stall, fsel_rs_D, fsel_rt_D, fsel_rs_E, fsel_rt_E, fsel_rt_M
  );

endinterface

// File: rtl/fwd_pick.sv
// One operand's forward select: compares a source index against the E/M/W slots, nearest hit wins.
module fwd_pick
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic [RW-1:0] src,
  input  logic          use_e,
  input  logic          use_m,
  input  logic [RW-1:0] e_a3,
  input  logic [TW-1:0] e_tnew,
  input  rk_e           e_kind,
  input  logic [RW-1:0] m_a3,
  input  logic [TW-1:0] m_tnew,
  input  rk_e           m_kind,
  input  logic [RW-1:0] w_a3,
  output mf_e           fsel
);

  logic hit_e;
  logic hit_m;
  logic hit_w;

  always_comb begin
    hit_e = use_e && (src != '0) && (src == e_a3);
    hit_m = use_m && (src != '0) && (src == m_a3);
    hit_w = (src != '0) && (src == w_a3);
  end

  // A nearer hit whose value is not yet ready blocks farther (stale) hits.
  always_comb begin
    fsel = MF_RD;
    if (hit_e) begin
      if (e_tnew == '0 && e_kind == RK_LINK) fsel = MF_PC4E;
    end else if (hit_m) begin
      if (m_tnew == '0) begin
        if (m_kind == RK_ALU)       fsel = MF_AO;
        else if (m_kind == RK_LINK) fsel = MF_PC4M;
      end
    end else if (hit_w) begin
      fsel = MF_WD;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Tuse/Tnew hazard controller: shadow E/M/W pipeline drives the stall and every forward select.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int unsigned RW = RW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input logic             clk,
  input logic             reset,
  hazard_fwd_ctrl_if.slave bus
);

  typedef struct packed {
    logic [RW-1:0] a3;
    logic [TW-1:0] tnew;
    rk_e           kind;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
  } e_slot_t;

  // M only needs rt (store data); W only needs a3 since its tnew is always 0.
  typedef struct packed {
    logic [RW-1:0] a3;
    logic [TW-1:0] tnew;
    rk_e           kind;
    logic [RW-1:0] rt;
  } m_slot_t;

  e_slot_t       e_q;
  m_slot_t       m_q;
  logic [RW-1:0] w_a3;
  logic          stall_raw;

  mf_e pick_rs_d;
  mf_e pick_rt_d;
  mf_e pick_rs_e;
  mf_e pick_rt_e;
  mf_e pick_rt_m;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic needs_stall(input logic [RW-1:0] src, input logic [RW-1:0] a3,
                                       input logic [TW-1:0] tnew, input logic [TW-1:0] tuse);
    return (src != '0) && (src == a3) && (tnew > tuse);
  endfunction

  always_comb begin
    stall_raw = needs_stall(bus.rs_D, e_q.a3, e_q.tnew, bus.tuse_rs_D)
              | needs_stall(bus.rs_D, m_q.a3, m_q.tnew, bus.tuse_rs_D)
              | needs_stall(bus.rt_D, e_q.a3, e_q.tnew, bus.tuse_rt_D)
              | needs_stall(bus.rt_D, m_q.a3, m_q.tnew, bus.tuse_rt_D);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q  <= '0;
      m_q  <= '0;
      w_a3 <= '0;
    end else begin
      w_a3 <= m_q.a3;
      m_q  <= '{a3: e_q.a3, tnew: sat_dec(e_q.tnew), kind: e_q.kind, rt: e_q.rt};
      if (stall_raw) begin
        e_q <= '0;
      end else begin
        e_q <= '{a3: bus.a3_D, tnew: bus.tnew_D, kind: bus.kind_D,
                 rs: bus.rs_D, rt: bus.rt_D};
      end
    end
  end

  fwd_pick #(.RW(RW), .TW(TW)) u_pick_rs_d (
    .src(bus.rs_D), .use_e(1'b1), .use_m(1'b1),
    .e_a3(e_q.a3), .e_tnew(e_q.tnew), .e_kind(e_q.kind),
    .m_a3(m_q.a3), .m_tnew(m_q.tnew), .m_kind(m_q.kind),
    .w_a3(w_a3), .fsel(pick_rs_d)
  );

  fwd_pick #(.RW(RW), .TW(TW)) u_pick_rt_d (
    .src(bus.rt_D), .use_e(1'b1), .use_m(1'b1),
    .e_a3(e_q.a3), .e_tnew(e_q.tnew), .e_kind(e_q.kind),
    .m_a3(m_q.a3), .m_tnew(m_q.tnew), .m_kind(m_q.kind),
    .w_a3(w_a3), .fsel(pick_rt_d)
  );

  fwd_pick #(.RW(RW), .TW(TW)) u_pick_rs_e (
    .src(e_q.rs), .use_e(1'b0), .use_m(1'b1),
    .e_a3('0), .e_tnew('0), .e_kind(RK_ALU),
    .m_a3(m_q.a3), .m_tnew(m_q.tnew), .m_kind(m_q.kind),
    .w_a3(w_a3), .fsel(pick_rs_e)
  );

  fwd_pick #(.RW(RW), .TW(TW)) u_pick_rt_e (
    .src(e_q.rt), .use_e(1'b0), .use_m(1'b1),
    .e_a3('0), .e_tnew('0), .e_kind(RK_ALU),
    .m_a3(m_q.a3), .m_tnew(m_q.tnew), .m_kind(m_q.kind),
    .w_a3(w_a3), .fsel(pick_rt_e)
  );

  fwd_pick #(.RW(RW), .TW(TW)) u_pick_rt_m (
    .src(m_q.rt), .use_e(1'b0), .use_m(1'b0),
    .e_a3('0), .e_tnew('0), .e_kind(RK_ALU),
    .m_a3('0), .m_tnew('0), .m_kind(RK_ALU),
    .w_a3(w_a3), .fsel(pick_rt_m)
  );

  // Reset masks the stale shadow contents so the outputs are quiet in the reset cycle itself.
  always_comb begin
    bus.stall     = !reset && stall_raw;
    bus.fsel_rs_D = reset ? MF_RD : pick_rs_d;
    bus.fsel_rt_D = reset ? MF_RD : pick_rt_d;
    bus.fsel_rs_E = reset ? MF_RD : pick_rs_e;
    bus.fsel_rt_E = reset ? MF_RD : pick_rt_e;
    bus.fsel_rt_M = reset ? MF_RD : pick_rt_m;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed-vector bench for hazard_fwd_ctrl with hand-derived stall/forward expectations.
module tb_hazard_fwd_ctrl;
  import hazard_fwd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  hazard_fwd_ctrl_if #(.RW(5), .TW(2)) bus ();

  hazard_fwd_ctrl #(.RW(5), .TW(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tnew, input rk_e kind);
    bus.rs_D = rs;  bus.rt_D = rt;
    bus.tuse_rs_D = tu_rs;  bus.tuse_rt_D = tu_rt;
    bus.a3_D = a3;  bus.tnew_D = tnew;  bus.kind_D = kind;
  endtask

  task automatic nop_d();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, RK_ALU);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic flush();
    nop_d();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [14:0] all_rd;
    logic [14:0] got;
    all_rd = {MF_RD, MF_RD, MF_RD, MF_RD, MF_RD};
    reset = 1'b0;
    flush();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, RK_MEM);
    tick();
    // Consumer of $8 with tuse 0 would stall if reset did not mask it.
    drive(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, RK_ALU);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (c == 1)
        drive(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
              5'($urandom), 2'($urandom), rk_e'($urandom_range(0, 2)));
      settle();
      tests++;
      if (bus.stall !== 1'b0) begin
        fails++;
        $display("FAIL reset_stall cyc%0d got %0b want 0", c, bus.stall);
      end
      got = {bus.fsel_rs_D, bus.fsel_rt_D, bus.fsel_rs_E, bus.fsel_rt_E, bus.fsel_rt_M};
      tests++;
      if (got !== all_rd) begin
        fails++;
        $display("FAIL reset_fsel cyc%0d got %h want %h", c, got, all_rd);
      end
      tick();
    end
    reset = 1'b0;
    drive(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_stall got %0b want 0", bus.stall);
    end
    tests++;
    if (bus.fsel_rs_D !== MF_RD) begin
      fails++;
      $display("FAIL reset_release_fsel got %0d want %0d", bus.fsel_rs_D, MF_RD);
    end
    flush();
  endtask

  task automatic test_load_use();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, RK_MEM);
    tick();
    // rt=$10 matches its own dest with tuse 0: a missing E bubble would stall again.
    drive(5'd8, 5'd10, 2'd1, 2'd0, 5'd10, 2'd1, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL load_use_stall1 got %0b want 1", bus.stall);
    end
    tick();
    settle();
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL load_use_stall2 got %0b want 0", bus.stall);
    end
    tests++;
    if (bus.fsel_rs_D !== MF_RD) begin
      fails++;
      $display("FAIL load_use_block got %0d want %0d", bus.fsel_rs_D, MF_RD);
    end
    tick();
    nop_d();
    settle();
    tests++;
    if (bus.fsel_rs_E !== MF_WD || bus.fsel_rt_E !== MF_RD) begin
      fails++;
      $display("FAIL load_use_e got rs=%0d rt=%0d want rs=%0d rt=%0d",
               bus.fsel_rs_E, bus.fsel_rt_E, MF_WD, MF_RD);
    end
    flush();
  endtask

  task automatic test_load_branch();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, RK_MEM);
    tick();
    drive(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, RK_ALU);
    for (int c = 0; c < 2; c++) begin
      settle();
      tests++;
      if (bus.stall !== 1'b1) begin
        fails++;
        $display("FAIL load_branch_stall cyc%0d got %0b want 1", c, bus.stall);
      end
      tick();
    end
    settle();
    tests++;
    if (bus.stall !== 1'b0 || bus.fsel_rs_D !== MF_WD) begin
      fails++;
      $display("FAIL load_branch_fwd got stall=%0b fsel=%0d want stall=0 fsel=%0d",
               bus.stall, bus.fsel_rs_D, MF_WD);
    end
    flush();
  endtask

  task automatic test_alu_branch();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, RK_ALU);
    tick();
    drive(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL alu_branch_stall got %0b want 1", bus.stall);
    end
    tick();
    settle();
    tests++;
    if (bus.stall !== 1'b0 || bus.fsel_rs_D !== MF_AO) begin
      fails++;
      $display("FAIL alu_branch_fwd got stall=%0b fsel=%0d want stall=0 fsel=%0d",
               bus.stall, bus.fsel_rs_D, MF_AO);
    end
    flush();
  endtask

  task automatic test_link();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, RK_LINK);
    tick();
    drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b0 || bus.fsel_rs_D !== MF_PC4E) begin
      fails++;
      $display("FAIL link_d got stall=%0b fsel=%0d want stall=0 fsel=%0d",
               bus.stall, bus.fsel_rs_D, MF_PC4E);
    end
    tick();
    nop_d();
    settle();
    tests++;
    if (bus.fsel_rs_E !== MF_PC4M) begin
      fails++;
      $display("FAIL link_e got %0d want %0d", bus.fsel_rs_E, MF_PC4M);
    end
    flush();
  endtask

  task automatic test_nearest();
    for (int v = 0; v < 2; v++) begin
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, RK_ALU);
      tick();
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, RK_ALU);
      tick();
      drive((v == 0) ? 5'd5 : 5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, RK_ALU);
      settle();
      tests++;
      if (bus.stall !== 1'b0) begin
        fails++;
        $display("FAIL nearest_stall v%0d got %0b want 0", v, bus.stall);
      end
      tick();
      nop_d();
      settle();
      tests++;
      if (bus.fsel_rs_E !== ((v == 0) ? MF_AO : MF_RD)) begin
        fails++;
        $display("FAIL nearest_e v%0d got %0d want %0d", v, bus.fsel_rs_E,
                 (v == 0) ? MF_AO : MF_RD);
      end
      flush();
    end
  endtask

  task automatic test_zero();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, RK_MEM);
    tick();
    drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b0 || bus.fsel_rs_D !== MF_RD || bus.fsel_rt_D !== MF_RD) begin
      fails++;
      $display("FAIL zero_reg got stall=%0b rs=%0d rt=%0d want 0 %0d %0d",
               bus.stall, bus.fsel_rs_D, bus.fsel_rt_D, MF_RD, MF_RD);
    end
    flush();
  endtask

  task automatic test_store();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, RK_MEM);
    tick();
    drive(5'd29, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0, RK_ALU);
    settle();
    tests++;
    if (bus.stall !== 1'b0 || bus.fsel_rt_D !== MF_RD) begin
      fails++;
      $display("FAIL store_d got stall=%0b fsel=%0d want stall=0 fsel=%0d",
               bus.stall, bus.fsel_rt_D, MF_RD);
    end
    tick();
    nop_d();
    settle();
    tests++;
    if (bus.fsel_rt_E !== MF_RD) begin
      fails++;
      $display("FAIL store_e_mem_no_ao got %0d want %0d", bus.fsel_rt_E, MF_RD);
    end
    tick();
    settle();
    tests++;
    if (bus.fsel_rt_M !== MF_WD) begin
      fails++;
      $display("FAIL store_m got %0d want %0d", bus.fsel_rt_M, MF_WD);
    end
    flush();
  endtask

  initial begin
    nop_d();
    repeat (2) tick();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_link();
    test_nearest();
    test_zero();
    test_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
